control_sequencer: RTL

Multicycle control-unit state machine for the MIPS datapath. Sits directly downstream of the instruction state encoder: it runs the fetch sequence and samples the encoder's 7-bit `State_Sel` in its DECODE state to branch into the per-instruction execution states. It also issues datapath register-load and memory strobes, and supervises the memory MOC handshake with a timeout.

---
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
// Multicycle control FSM for the MIPS datapath. It runs the instruction fetch,
// branches on the encoder's State_Sel in DECODE, drives the datapath load and
// memory strobes, and watches the MOC handshake. If MOC does not arrive within
// MOC_TIMEOUT wait cycles, the FSM halts in BUS_ERR until the next reset.
//
// Ports
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   State_Sel  target state from the encoder, sampled only when leaving DECODE
//   MOC        memory operation complete, sampled only in wait states
//   Cond       ALU zero flag, sampled only when leaving BEQ_TEST
//   Cur_State  current state register (the codes match the encoder)
//   *_Ld       datapath register loads
//   PC_Src     0 = PC+4, 1 = branch target
//   RF_Src     0 = ALU result, 1 = MDR
//   MEM_Rd/Wr  memory strobes
//   Illegal    one-cycle pulse in ILLEGAL
//   Bus_Err    high while halted after a MOC timeout
//
// state          | meaning
// 0  RESET       | post-reset idle, no outputs
// 1  FETCH_ADDR  | load MAR with PC
// 2  FETCH_WAIT  | memory read, wait for MOC
// 3  FETCH_DONE  | load IR, PC <= PC+4
// 4  DECODE      | branch on State_Sel
// 5  BUS_ERR     | MOC timeout, halted until reset
// 6,17-23 ALU    | write ALU result to register file
// 7  STORE_ADDR  | load MAR
// 8  STORE_DATA  | load MDR
// 9  STORE_WAIT  | memory write, wait for MOC
// 10 ILLEGAL     | unrecognised instruction
// 11 BEQ_TEST    | branch on Cond
// 12 BEQ_TAKE    | PC <= branch target
// 13 LOAD_ADDR   | load MAR
// 14 LOAD_WAIT   | memory read into MDR, wait for MOC
// 15 LOAD_WB     | write MDR to register file
// other codes    | recover to RESET

module control_sequencer #(
   parameter int MOC_TIMEOUT = 15
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [6:0] State_Sel,
   input  logic       MOC,
   input  logic       Cond,
   output logic [6:0] Cur_State,
   output logic       MAR_Ld,
   output logic       MDR_Ld,
   output logic       IR_Ld,
   output logic       PC_Ld,
   output logic       RF_Ld,
   output logic       PC_Src,
   output logic       RF_Src,
   output logic       MEM_Rd,
   output logic       MEM_Wr,
   output logic       Illegal,
   output logic       Bus_Err
);

   localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

   typedef enum logic [6:0] {
      S_RESET      = 7'd0,
      S_FETCH_ADDR = 7'd1,
      S_FETCH_WAIT = 7'd2,
      S_FETCH_DONE = 7'd3,
      S_DECODE     = 7'd4,
      S_BUS_ERR    = 7'd5,
      S_ALU_6      = 7'd6,
      S_STORE_ADDR = 7'd7,
      S_STORE_DATA = 7'd8,
      S_STORE_WAIT = 7'd9,
      S_ILLEGAL    = 7'd10,
      S_BEQ_TEST   = 7'd11,
      S_BEQ_TAKE   = 7'd12,
      S_LOAD_ADDR  = 7'd13,
      S_LOAD_WAIT  = 7'd14,
      S_LOAD_WB    = 7'd15,
      S_ALU_17     = 7'd17,
      S_ALU_18     = 7'd18,
      S_ALU_19     = 7'd19,
      S_ALU_20     = 7'd20,
      S_ALU_21     = 7'd21,
      S_ALU_22     = 7'd22,
      S_ALU_23     = 7'd23
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_wait;
   logic             timeout_hit;
   logic             sel_legal;

   assign in_wait = (state_q == S_FETCH_WAIT) || (state_q == S_STORE_WAIT) ||
                    (state_q == S_LOAD_WAIT);

   // MOC takes priority: a timeout only counts on a cycle where MOC is low.
   assign timeout_hit = in_wait && !MOC && (cnt_q == CNT_LAST);

   always_comb begin
      sel_legal = 1'b0;
      case (State_Sel)
         7'd6, 7'd7, 7'd11, 7'd13,
         7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22, 7'd23: sel_legal = 1'b1;
         default:                                          sel_legal = 1'b0;
      endcase
   end

   // The counter never reaches MOC_TIMEOUT, because the FSM leaves the wait
   // state on the CNT_LAST cycle. That is why no wrap guard is needed.
   always_comb begin
      cnt_d = '0;
      if (in_wait && !MOC && !timeout_hit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = S_RESET;
      case (state_q)
         S_RESET:      state_d = S_FETCH_ADDR;
         S_FETCH_ADDR: state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: state_d = MOC ? S_FETCH_DONE :
                                 (timeout_hit ? S_BUS_ERR : S_FETCH_WAIT);
         S_FETCH_DONE: state_d = S_DECODE;
         S_DECODE:     state_d = sel_legal ? state_e'(State_Sel) : S_ILLEGAL;
         S_BUS_ERR:    state_d = S_BUS_ERR;
         S_ALU_6, S_ALU_17, S_ALU_18, S_ALU_19,
         S_ALU_20, S_ALU_21, S_ALU_22, S_ALU_23:
                       state_d = S_FETCH_ADDR;
         S_STORE_ADDR: state_d = S_STORE_DATA;
         S_STORE_DATA: state_d = S_STORE_WAIT;
         S_STORE_WAIT: state_d = MOC ? S_FETCH_ADDR :
                                 (timeout_hit ? S_BUS_ERR : S_STORE_WAIT);
         S_ILLEGAL:    state_d = S_FETCH_ADDR;
         S_BEQ_TEST:   state_d = Cond ? S_BEQ_TAKE : S_FETCH_ADDR;
         S_BEQ_TAKE:   state_d = S_FETCH_ADDR;
         S_LOAD_ADDR:  state_d = S_LOAD_WAIT;
         S_LOAD_WAIT:  state_d = MOC ? S_LOAD_WB :
                                 (timeout_hit ? S_BUS_ERR : S_LOAD_WAIT);
         S_LOAD_WB:    state_d = S_FETCH_ADDR;
         default:      state_d = S_RESET;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Cur_State = state_q;

   // Moore decode of the state register. Because of this decode, an async
   // reset drops every strobe in the same cycle.
   always_comb begin
      MAR_Ld  = 1'b0;
      MDR_Ld  = 1'b0;
      IR_Ld   = 1'b0;
      PC_Ld   = 1'b0;
      RF_Ld   = 1'b0;
      PC_Src  = 1'b0;
      RF_Src  = 1'b0;
      MEM_Rd  = 1'b0;
      MEM_Wr  = 1'b0;
      Illegal = 1'b0;
      Bus_Err = 1'b0;
      case (state_q)
         S_FETCH_ADDR: MAR_Ld = 1'b1;
         S_FETCH_WAIT: MEM_Rd = 1'b1;
         S_FETCH_DONE: begin
            MEM_Rd = 1'b1;
            IR_Ld  = 1'b1;
            PC_Ld  = 1'b1;
         end
         S_BUS_ERR:    Bus_Err = 1'b1;
         S_ALU_6, S_ALU_17, S_ALU_18, S_ALU_19,
         S_ALU_20, S_ALU_21, S_ALU_22, S_ALU_23:
                       RF_Ld = 1'b1;
         S_STORE_ADDR: MAR_Ld = 1'b1;
         S_STORE_DATA: MDR_Ld = 1'b1;
         S_STORE_WAIT: MEM_Wr = 1'b1;
         S_ILLEGAL:    Illegal = 1'b1;
         S_BEQ_TAKE: begin
            PC_Ld  = 1'b1;
            PC_Src = 1'b1;
         end
         S_LOAD_ADDR:  MAR_Ld = 1'b1;
         S_LOAD_WAIT: begin
            MEM_Rd = 1'b1;
            MDR_Ld = 1'b1;
            RF_Src = 1'b1;
         end
         S_LOAD_WB: begin
            RF_Ld  = 1'b1;
            RF_Src = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
